sub_unit: RTL

Handshaked, pipelined inverse of the combinational adder datapath: given a sum `C` and one addend `A`, it recovers the other addend `B = C - A` (mod 2^WIDTH). It sits between the debugger bench's operand source and result sink. The block has one register stage, then an output FIFO that absorbs sink backpressure. A running count of completed results is exported for the debugger to poll.

---
 rtl/sub_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/sub_unit.sv
// ============================================================================
// Module   : sub_unit
// Purpose  : Handshaked inverse adder, B = C - A (mod 2^WIDTH), with a single
//            stage register feeding an output FIFO. Optional SUB_BORROW_EN adds
//            the borrow flag (C < A, unsigned) to every result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] B,
`ifdef SUB_BORROW_EN
    output logic             borrow,
`endif
    output logic [31:0]      txn_cnt
);

    localparam int c_AW = $clog2(DEPTH);
`ifdef SUB_BORROW_EN
    localparam int c_EW = WIDTH + 1;
`else
    localparam int c_EW = WIDTH;
`endif
    localparam logic [c_AW+1:0] c_DEPTH   = (c_AW+2)'(DEPTH);
    localparam logic [c_AW:0]   c_PTR_ONE = (c_AW+1)'(1);

    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_EW-1:0] r_s1;
    logic            r_s1_valid;
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [31:0]     r_txn_cnt;

    logic [WIDTH-1:0] w_diff;
    logic [c_EW-1:0]  w_entry;
    logic [c_AW:0]    w_count;
    logic [c_AW+1:0]  w_level;
    logic             w_empty;
    logic             w_accept;
    logic             w_pop;
    logic [c_EW-1:0]  w_head;

    assign w_diff = C - A;
`ifdef SUB_BORROW_EN
    assign w_entry = {(C < A), w_diff};
`else
    assign w_entry = w_diff;
`endif

    // Space is reserved for the S1 entry as well, so S1 can always push.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_level  = {1'b0, w_count} + {{(c_AW+1){1'b0}}, r_s1_valid};
    assign in_ready = (w_level < c_DEPTH);

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign out_valid = ~w_empty;
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign B       = w_head[WIDTH-1:0];
`ifdef SUB_BORROW_EN
    assign borrow  = w_head[WIDTH];
`endif
    assign txn_cnt = r_txn_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_txn_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1 <= w_entry;
            end
            if (r_s1_valid) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= r_s1;
                r_wr_ptr                  <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_txn_cnt <= r_txn_cnt + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire
